fp_divider_unit: RTL



---
 rtl/fp_pkg.sv | 25 ++
 rtl/fp_classify.sv | 19 +
 rtl/fp_divider_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared constants, special-case flag encoding and state type for the
// floating-point divider and its multiplier companion.
package fp_pkg;

    localparam int unsigned BIAS  = 127;
    localparam int unsigned QBITS = 25;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    localparam logic [4:0] FLAG_PZERO = 5'b10000;
    localparam logic [4:0] FLAG_NZERO = 5'b01000;
    localparam logic [4:0] FLAG_PINF  = 5'b00100;
    localparam logic [4:0] FLAG_NINF  = 5'b00010;
    localparam logic [4:0] FLAG_NAN   = 5'b00001;
    localparam logic [4:0] FLAG_NONE  = 5'b00000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPECIAL,
        S_DIVIDE,
        S_NORMALIZE,
        S_DONE
    } div_state_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single-precision operand classifier.
// Denormals are flushed, so a zero exponent always reads as zero.
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0] op,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan
);

    logic exp_max;

    assign exp_max = (op[30:23] == 8'hFF);
    assign is_zero = (op[30:23] == 8'h00);
    assign is_inf  = exp_max && (op[22:0] == 23'd0);
    assign is_nan  = exp_max && (op[22:0] != 23'd0);

endmodule

// File: rtl/fp_divider_unit.sv
// Sequential single-precision divider: restoring mantissa division, one
// quotient bit per cycle, truncating, with start/busy/done handshake.
module fp_divider_unit
    import fp_pkg::*;
#(
    parameter int unsigned P_BIAS  = BIAS,
    parameter int unsigned P_QBITS = QBITS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    output logic        busy,
    output logic        done,
    output logic [31:0] dataR,
    output logic [4:0]  casesspecial
);

    div_state_t state;

    logic [7:0]         exp_a, exp_b;
    logic [23:0]        div_q;
    logic [P_QBITS-1:0] rem_q;
    logic [P_QBITS-1:0] quo_q;
    logic [4:0]         cnt_q;
    logic               sign_q;
    logic               za_q, zb_q, ia_q, ib_q, na_q, nb_q;

    logic za_in, zb_in, ia_in, ib_in, na_in, nb_in;

    fp_classify u_class_a (.op(dataA), .is_zero(za_in), .is_inf(ia_in), .is_nan(na_in));
    fp_classify u_class_b (.op(dataB), .is_zero(zb_in), .is_inf(ib_in), .is_nan(nb_in));

    // One restoring step: compare, conditionally subtract, then shift.
    logic               qbit;
    logic [P_QBITS-1:0] div_ext;
    logic [P_QBITS-1:0] rem_sub;

    always_comb begin
        div_ext = {1'b0, div_q};
        qbit    = (rem_q >= div_ext);
        rem_sub = qbit ? (rem_q - div_ext) : rem_q;
    end

    // Special-case result, priority NaN > infinity > zero.
    logic [31:0] spec_r;
    logic [4:0]  spec_flag;

    always_comb begin
        spec_r    = {sign_q, 31'd0};
        spec_flag = sign_q ? FLAG_NZERO : FLAG_PZERO;
        if (na_q || nb_q || (za_q && zb_q) || (ia_q && ib_q)) begin
            spec_r    = QNAN;
            spec_flag = FLAG_NAN;
        end else if (ia_q || zb_q) begin
            spec_r    = {sign_q, 8'hFF, 23'd0};
            spec_flag = sign_q ? FLAG_NINF : FLAG_PINF;
        end
    end

    // Normalization: the quotient lies in [0.5, 2), so at most one shift.
    logic signed [9:0] exp_norm;
    logic [22:0]       mant_norm;
    logic [31:0]       norm_r;
    logic [4:0]        norm_flag;

    always_comb begin
        exp_norm = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + $signed(10'(P_BIAS));
        if (quo_q[P_QBITS-1]) begin
            mant_norm = quo_q[P_QBITS-2:1];
        end else begin
            mant_norm = quo_q[P_QBITS-3:0];
            exp_norm  = exp_norm - 10'sd1;
        end
        norm_r    = {sign_q, exp_norm[7:0], mant_norm};
        norm_flag = FLAG_NONE;
        if (exp_norm >= 10'sd255) begin
            norm_r    = {sign_q, 8'hFF, 23'd0};
            norm_flag = sign_q ? FLAG_NINF : FLAG_PINF;
        end else if (exp_norm <= 10'sd0) begin
            norm_r    = {sign_q, 31'd0};
            norm_flag = sign_q ? FLAG_NZERO : FLAG_PZERO;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            dataR        <= 32'd0;
            casesspecial <= 5'd0;
            exp_a        <= 8'd0;
            exp_b        <= 8'd0;
            div_q        <= 24'd0;
            rem_q        <= '0;
            quo_q        <= '0;
            cnt_q        <= 5'd0;
            sign_q       <= 1'b0;
            {za_q, zb_q, ia_q, ib_q, na_q, nb_q} <= 6'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy   <= 1'b1;
                        sign_q <= dataA[31] ^ dataB[31];
                        exp_a  <= dataA[30:23];
                        exp_b  <= dataB[30:23];
                        rem_q  <= {1'b0, 1'b1, dataA[22:0]};
                        div_q  <= {1'b1, dataB[22:0]};
                        quo_q  <= '0;
                        cnt_q  <= 5'd0;
                        {za_q, zb_q, ia_q, ib_q, na_q, nb_q} <=
                            {za_in, zb_in, ia_in, ib_in, na_in, nb_in};
                        if (za_in || zb_in || ia_in || ib_in || na_in || nb_in)
                            state <= S_SPECIAL;
                        else
                            state <= S_DIVIDE;
                    end
                end
                S_SPECIAL: begin
                    dataR        <= spec_r;
                    casesspecial <= spec_flag;
                    done         <= 1'b1;
                    state        <= S_DONE;
                end
                S_DIVIDE: begin
                    rem_q <= {rem_sub[P_QBITS-2:0], 1'b0};
                    quo_q <= {quo_q[P_QBITS-2:0], qbit};
                    if (cnt_q == 5'(P_QBITS - 1))
                        state <= S_NORMALIZE;
                    else
                        cnt_q <= cnt_q + 5'd1;
                end
                S_NORMALIZE: begin
                    dataR        <= norm_r;
                    casesspecial <= norm_flag;
                    done         <= 1'b1;
                    state        <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
